// File: rtl/multdiv_pkg.sv
// Shared encodings and op-class helpers for the HI/LO multiply-divide unit.
package multdiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MADD  = 3'd4;
   localparam logic [2:0] MD_MADDU = 3'd5;
   localparam logic [2:0] MD_MSUB  = 3'd6;
   localparam logic [2:0] MD_MSUBU = 3'd7;

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_acc(input logic [2:0] op);
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   function automatic logic is_sub(input logic [2:0] op);
      return (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   // Even encodings are the signed flavours.
   function automatic logic is_signed(input logic [2:0] op);
      return (op[0] == 1'b0);
   endfunction

endpackage

// File: rtl/multdiv_param_md_calc.sv
// Combinational result generator: products, accumulate and divide with defined
// divide-by-zero and overflow results, packed as {hi, lo}.
module md_calc
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         md_op,
   input  logic [WIDTH-1:0]   hi,
   input  logic [WIDTH-1:0]   lo,
   output logic [2*WIDTH-1:0] result,
   output logic               div0
);

   logic                 sgn_s;
   logic [2*WIDTH-1:0]   a_ext_s;
   logic [2*WIDTH-1:0]   b_ext_s;
   logic [2*WIDTH-1:0]   prod_s;
   logic [2*WIDTH-1:0]   acc_s;
   logic                 a_neg_s;
   logic                 b_neg_s;
   logic                 b_zero_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic [WIDTH-1:0]     b_safe_s;
   logic [WIDTH-1:0]     q_mag_s;
   logic [WIDTH-1:0]     r_mag_s;
   logic [WIDTH-1:0]     quot_s;
   logic [WIDTH-1:0]     rem_s;

   assign sgn_s   = is_signed(md_op);
   assign a_ext_s = sgn_s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign b_ext_s = sgn_s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod_s  = a_ext_s * b_ext_s;
   assign acc_s   = {hi, lo};

   // Signed divide runs on magnitudes; MIN/-1 then wraps to MIN with zero remainder.
   assign a_neg_s  = sgn_s & a[WIDTH-1];
   assign b_neg_s  = sgn_s & b[WIDTH-1];
   assign a_mag_s  = a_neg_s ? -a : a;
   assign b_mag_s  = b_neg_s ? -b : b;
   assign b_zero_s = (b == {WIDTH{1'b0}});
   assign b_safe_s = b_zero_s ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag_s;
   assign q_mag_s  = a_mag_s / b_safe_s;
   assign r_mag_s  = a_mag_s % b_safe_s;
   assign quot_s   = (a_neg_s ^ b_neg_s) ? -q_mag_s : q_mag_s;
   assign rem_s    = a_neg_s ? -r_mag_s : r_mag_s;

   // Select the final {hi, lo} image for the requested op class.
   always_comb begin
      result = prod_s;
      div0   = 1'b0;
      if (is_div(md_op)) begin
         if (b_zero_s) begin
            result = {a, {WIDTH{1'b1}}};
            div0   = 1'b1;
         end else begin
            result = {rem_s, quot_s};
            div0   = 1'b0;
         end
      end else if (is_acc(md_op)) begin
         if (is_sub(md_op)) begin
            result = acc_s - prod_s;
         end else begin
            result = acc_s + prod_s;
         end
      end else begin
         result = prod_s;
      end
   end

endmodule

// File: rtl/multdiv_param.sv
// HI/LO multiply-divide unit: latency counter, pending result, HI/LO/div0
// registers, mthi/mtlo and exception flush.
module multdiv_param
   import multdiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       md_op,
   input  logic             start,
   input  logic             hi_write,
   input  logic             lo_write,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam logic [CNT_W-1:0] MULT_C = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_C  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]   cnt_r;
   logic [CNT_W-1:0]   cnt_nxt_s;
   logic [2*WIDTH-1:0] pend_r;
   logic               pend_div_r;
   logic               pend_div0_r;
   logic [2*WIDTH-1:0] calc_res_s;
   logic               calc_div0_s;
   logic               idle_s;
   logic               launch_s;
   logic               done_s;
   logic               mt_en_s;

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .a      (a),
      .b      (b),
      .md_op  (md_op),
      .hi     (hi),
      .lo     (lo),
      .result (calc_res_s),
      .div0   (calc_div0_s)
   );

   assign idle_s = (cnt_r == {CNT_W{1'b0}});

   // Counter sequencing: flush beats both launch and completion.
   always_comb begin
      cnt_nxt_s = cnt_r;
      launch_s  = 1'b0;
      done_s    = 1'b0;
      mt_en_s   = 1'b0;
      if (idle_s) begin
         mt_en_s = ~start;
         if (start && !flush) begin
            launch_s  = 1'b1;
            cnt_nxt_s = is_div(md_op) ? DIV_C : MULT_C;
         end else begin
            cnt_nxt_s = {CNT_W{1'b0}};
         end
      end else if (flush) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r - ONE_C;
         done_s    = (cnt_r == ONE_C);
      end
   end

   // State registers; hi/lo move only on completion or an idle mthi/mtlo.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r       <= {CNT_W{1'b0}};
         busy        <= 1'b0;
         pend_r      <= {(2*WIDTH){1'b0}};
         pend_div_r  <= 1'b0;
         pend_div0_r <= 1'b0;
         hi          <= {WIDTH{1'b0}};
         lo          <= {WIDTH{1'b0}};
         div0        <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         busy  <= (cnt_nxt_s != {CNT_W{1'b0}});
         if (launch_s) begin
            pend_r      <= calc_res_s;
            pend_div_r  <= is_div(md_op);
            pend_div0_r <= calc_div0_s;
         end
         if (done_s) begin
            hi <= pend_r[2*WIDTH-1:WIDTH];
            lo <= pend_r[WIDTH-1:0];
            if (pend_div_r) begin
               div0 <= pend_div0_r;
            end
         end else if (mt_en_s) begin
            if (hi_write) begin
               hi <= a;
            end
            if (lo_write) begin
               lo <= a;
            end
         end
      end
   end

endmodule

// File: tb/tb_multdiv_param.sv
// Self-checking bench for multdiv_param: directed vector table, hand-written
// corner sequences and randomized ops against a plain-arithmetic model.
module tb_multdiv_param;

   localparam int W  = 32;
   localparam int ML = 5;
   localparam int DL = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [2:0]    md_op = 3'd0;
   logic          start = 1'b0;
   logic          hi_write = 1'b0;
   logic          lo_write = 1'b0;
   logic          flush = 1'b0;
   logic          busy;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          div0;

   int checks = 0;
   int errors = 0;

   logic [W-1:0]  m_hi = '0;
   logic [W-1:0]  m_lo = '0;
   logic          m_div0 = 1'b0;

   multdiv_param #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .md_op    (md_op),
      .start    (start),
      .hi_write (hi_write),
      .lo_write (lo_write),
      .flush    (flush),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .div0     (div0)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic         pre;
      logic [W-1:0] phi;
      logic [W-1:0] plo;
      logic [2:0]   op;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] ehi;
      logic [W-1:0] elo;
      logic         ediv0;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: architectural effect of one completed op.
   task automatic model_exec(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
      logic [63:0] p;
      logic [63:0] acc;
      longint      sa, sb, q, r;
      if (op == 3'd0 || op == 3'd4 || op == 3'd6) begin
         p = longint'($signed(va)) * longint'($signed(vb));
      end else begin
         p = {32'd0, va} * {32'd0, vb};
      end
      acc = {m_hi, m_lo};
      if (op == 3'd2 || op == 3'd3) begin
         if (vb == 32'd0) begin
            m_hi = va; m_lo = 32'hFFFF_FFFF; m_div0 = 1'b1;
         end else begin
            if (op == 3'd2) begin
               sa = longint'($signed(va)); sb = longint'($signed(vb));
            end else begin
               sa = longint'({32'd0, va}); sb = longint'({32'd0, vb});
            end
            q = sa / sb;
            r = sa % sb;
            m_lo = q[31:0]; m_hi = r[31:0]; m_div0 = 1'b0;
         end
      end else begin
         if (op == 3'd4 || op == 3'd5) acc = acc + p;
         else if (op == 3'd6 || op == 3'd7) acc = acc - p;
         else acc = p;
         {m_hi, m_lo} = acc;
      end
   endtask

   task automatic mt(input logic [W-1:0] hv, input logic [W-1:0] lv);
      @(negedge clk); a = hv; hi_write = 1'b1;
      @(negedge clk); hi_write = 1'b0; a = lv; lo_write = 1'b1;
      @(negedge clk); lo_write = 1'b0;
      m_hi = hv; m_lo = lv;
   endtask

   // Count busy cycles from the first negedge after launch; check hi/lo hold old values.
   task automatic wait_done(input string name, input int exp_n);
      int   n;
      logic stable;
      n = 0; stable = 1'b1;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
         @(negedge clk);
      end
      check({name, " busy_cycles"}, 64'(n), 64'(exp_n));
      check({name, " hilo_stable"}, {63'd0, stable}, 64'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk); md_op = op; a = va; b = vb; start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(name, (op == 3'd2 || op == 3'd3) ? DL : ML);
      model_exec(op, va, vb);
      check({name, " hi"}, {32'd0, hi}, {32'd0, m_hi});
      check({name, " lo"}, {32'd0, lo}, {32'd0, m_lo});
      check({name, " div0"}, {63'd0, div0}, {63'd0, m_div0});
   endtask

   function automatic logic [W-1:0] pick();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      tbl[0]  = '{1'b0, 32'd0, 32'd0, 3'd0, 32'hFFFF_FFFB, 32'd2,           32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0};
      tbl[1]  = '{1'b0, 32'd0, 32'd0, 3'd1, 32'hFFFF_FFFB, 32'd2,           32'h0000_0001, 32'hFFFF_FFF6, 1'b0};
      tbl[2]  = '{1'b0, 32'd0, 32'd0, 3'd2, 32'hFFFF_FFFB, 32'd2,           32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      tbl[3]  = '{1'b0, 32'd0, 32'd0, 3'd3, 32'hFFFF_FFFB, 32'd2,           32'h0000_0001, 32'h7FFF_FFFD, 1'b0};
      tbl[4]  = '{1'b0, 32'd0, 32'd0, 3'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFE,   32'hFFFF_FFFF, 32'h0000_0002, 1'b0};
      tbl[5]  = '{1'b0, 32'd0, 32'd0, 3'd2, 32'd7,         32'd0,           32'h0000_0007, 32'hFFFF_FFFF, 1'b1};
      tbl[6]  = '{1'b0, 32'd0, 32'd0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,   32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[7]  = '{1'b1, 32'd0, 32'd10, 3'd4, 32'd3,        32'd4,           32'h0000_0000, 32'd22,        1'b0};
      tbl[8]  = '{1'b1, 32'd0, 32'd0, 3'd6, 32'hFFFF_FFFB, 32'd2,           32'h0000_0000, 32'd10,        1'b0};
      tbl[9]  = '{1'b1, 32'd0, 32'd0, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,   32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      tbl[10] = '{1'b0, 32'd0, 32'd0, 3'd3, 32'd5,         32'd0,           32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
      tbl[11] = '{1'b0, 32'd0, 32'd0, 3'd1, 32'h0001_0000, 32'h0001_0000,   32'h0000_0001, 32'h0000_0000, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset hilo", {hi, lo}, 64'd0);
      check("reset div0", {63'd0, div0}, 64'd0);
      rst = 1'b1;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].pre) mt(tbl[i].phi, tbl[i].plo);
         run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].va, tbl[i].vb);
         check($sformatf("vec%0d tbl_hi", i), {32'd0, hi}, {32'd0, tbl[i].ehi});
         check($sformatf("vec%0d tbl_lo", i), {32'd0, lo}, {32'd0, tbl[i].elo});
         check($sformatf("vec%0d tbl_div0", i), {63'd0, div0}, {63'd0, tbl[i].ediv0});
      end

      // Flush in the third busy cycle of a divide
      mt(32'h0000_1234, 32'h0000_5678);
      @(negedge clk); md_op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      check("flush busy", {63'd0, busy}, 64'd0);
      repeat (DL + 2) @(negedge clk);
      check("flush hilo", {hi, lo}, {m_hi, m_lo});
      check("flush div0", {63'd0, div0}, {63'd0, m_div0});

      // start + mthi/mtlo while busy are ignored
      @(negedge clk); md_op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (n == 2) begin
            md_op = 3'd3; a = 32'hDEAD_BEEF; b = 32'd0; start = 1'b1; hi_write = 1'b1; lo_write = 1'b1;
         end else begin
            start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
      model_exec(3'd0, 32'd3, 32'd4);
      check("midbusy busy_cycles", 64'(n), 64'(ML));
      check("midbusy hilo", {hi, lo}, {m_hi, m_lo});
      check("midbusy div0", {63'd0, div0}, {63'd0, m_div0});
      @(negedge clk);
      check("midbusy idle_after", {63'd0, busy}, 64'd0);

      // start + flush in the same idle cycle: nothing launches
      @(negedge clk); md_op = 3'd0; a = 32'd7; b = 32'd7; start = 1'b1; flush = 1'b1;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      check("startflush busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("startflush hilo", {hi, lo}, {m_hi, m_lo});

      // start wins over mthi/mtlo in the same cycle
      @(negedge clk); md_op = 3'd1; a = 32'd6; b = 32'd7; start = 1'b1; hi_write = 1'b1; lo_write = 1'b1;
      @(negedge clk); start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
      wait_done("startwins", ML);
      model_exec(3'd1, 32'd6, 32'd7);
      check("startwins hilo", {hi, lo}, 64'd42);

      // mthi and mtlo together both take a
      @(negedge clk); a = 32'hCAFE_F00D; hi_write = 1'b1; lo_write = 1'b1;
      @(negedge clk); hi_write = 1'b0; lo_write = 1'b0;
      m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
      check("mtboth hilo", {hi, lo}, {m_hi, m_lo});

      // Asynchronous reset in the middle of a multiply
      run_op("pre_rst_div0", 3'd2, 32'd9, 32'd0);
      @(negedge clk); md_op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst busy", {63'd0, busy}, 64'd0);
      check("async_rst hilo", {hi, lo}, 64'd0);
      check("async_rst div0", {63'd0, div0}, 64'd0);
      @(negedge clk); rst = 1'b1;
      m_hi = '0; m_lo = '0; m_div0 = 1'b0;
      repeat (ML + 2) @(negedge clk);
      check("post_rst no_completion", {hi, lo}, 64'd0);
      run_op("post_rst mult", 3'd0, 32'hFFFF_FFFD, 32'd7);

      // Randomized ops against the model
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) mt(32'($urandom), 32'($urandom));
         run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
